// File: rtl/main_mem_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mem_sys_pkg
//   Shared geometry and types for the main-memory side of the data cache
//   subsystem: word/address widths, block geometry, the controller state
//   enum and a block-base helper.
//   WORDS_PER_BLOCK must be a power of two and at least 2 so that OFFSET_W
//   is non-zero.
// ---------------------------------------------------------------------------
package mem_sys_pkg;

    localparam int ADDR_W          = 10;                     // 1024 words
    localparam int DATA_W          = 32;
    localparam int WORDS_PER_BLOCK = 4;
    localparam int OFFSET_W        = $clog2(WORDS_PER_BLOCK);
    localparam int BLOCK_ADDR_W    = ADDR_W - OFFSET_W;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_WAIT  = 3'd1,
        ST_RD_BURST = 3'd2,
        ST_WR_BURST = 3'd3,
        ST_WR_WAIT  = 3'd4,
        ST_WR_DONE  = 3'd5
    } memState_e;

    // Word address of the first word of the block containing addr.
    function automatic logic [ADDR_W-1:0] blockBase(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/main_mem_ctrl_array.sv
// ---------------------------------------------------------------------------
// main_mem_array
//   2^ADDR_W x DATA_W storage with a synchronous write port and a registered
//   read port. The storage itself is never reset; only the read-data register
//   is cleared so the refill data bus starts at zero.
// Ports:
//   clk, rst      clock, asynchronous active-low reset (read register only)
//   wrEn/wrAddr/wrData   write one word on the rising edge
//   rdEn/rdAddr          capture mem[rdAddr] into rdData on the rising edge
//   rdData               registered read data
// ---------------------------------------------------------------------------
module main_mem_array
    import mem_sys_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wrEn,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0] wrData,
    input  logic              rdEn,
    input  logic [ADDR_W-1:0] rdAddr,
    output logic [DATA_W-1:0] rdData
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdData <= '0;
        end else if (rdEn) begin
            rdData <= mem[rdAddr];
        end
    end

endmodule

// File: rtl/main_mem_ctrl.sv
// ---------------------------------------------------------------------------
// main_mem_ctrl
//   Main-memory model and controller below the data cache. Serves whole-block
//   refills (read bursts) and write-backs (write bursts) over a word-serial
//   interface with a programmable access latency.
//
//   Handshakes: a request transfers on a rising edge where req_valid and
//   req_ready are both high (req_ready is high only in IDLE); a write-back
//   word transfers on an edge where wr_valid and wr_ready are both high.
//   Refill beats (rd_valid) have no backpressure.
//
//   Optional feature macro: MAIN_MEM_CRITICAL_WORD_FIRST_EN
//     defined   : a refill starts at req_addr's word offset and wraps within
//                 the block.
//     undefined : every refill starts at offset 0.
//     Write-backs always start at offset 0.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   req_valid/req_ready      block request handshake
//   req_write, req_addr      burst direction and word address
//   wr_valid/wr_ready/wr_data  write-back word stream
//   wr_done                  one-cycle pulse when a write-back completes
//   rd_valid/rd_data/rd_last refill word stream (registered)
//   dbgState                 current controller state
// ---------------------------------------------------------------------------
module main_mem_ctrl
    import mem_sys_pkg::*;
#(
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              wr_done,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output memState_e         dbgState
);

    // Latency counter holds LATENCY-1 down to 0.
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0]    LAT_LOAD = CNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);
    localparam logic [OFFSET_W-1:0] LAST_OFF = OFFSET_W'(WORDS_PER_BLOCK - 1);

    memState_e             state;
    logic [ADDR_W-1:0]     baseAddr;
    logic [OFFSET_W-1:0]   startOff;
    // One extra bit: in RD_BURST the top bit marks the trailing cycle that
    // carries rd_last while the controller is still busy.
    logic [OFFSET_W:0]     beat;
    logic [CNT_W-1:0]      latCnt;
    logic                  rdValidQ;
    logic                  rdLastQ;
    logic                  wrDoneQ;

    logic                  rdIssue;
    logic                  wrAccept;
    logic [OFFSET_W-1:0]   rdOff;
    logic [ADDR_W-1:0]     rdAddr;
    logic [ADDR_W-1:0]     wrAddr;

    assign req_ready = (state == ST_IDLE);
    assign wr_ready  = (state == ST_WR_BURST);
    assign rd_valid  = rdValidQ;
    assign rd_last   = rdLastQ;
    assign wr_done   = wrDoneQ;
    assign dbgState  = state;

    // Offset arithmetic is OFFSET_W wide, so it wraps inside the block.
    assign rdIssue  = (state == ST_RD_BURST) && !beat[OFFSET_W];
    assign wrAccept = (state == ST_WR_BURST) && wr_valid;
    assign rdOff    = startOff + beat[OFFSET_W-1:0];
    assign rdAddr   = baseAddr | ADDR_W'(rdOff);
    assign wrAddr   = baseAddr | ADDR_W'(beat[OFFSET_W-1:0]);

`ifndef MAIN_MEM_CRITICAL_WORD_FIRST_EN
    logic unusedOffsetBits;
    assign unusedOffsetBits = ^req_addr[OFFSET_W-1:0];
`endif

    main_mem_array u_array (
        .clk    (clk),
        .rst    (rst),
        .wrEn   (wrAccept),
        .wrAddr (wrAddr),
        .wrData (wr_data),
        .rdEn   (rdIssue),
        .rdAddr (rdAddr),
        .rdData (rd_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            baseAddr <= '0;
            startOff <= '0;
            beat     <= '0;
            latCnt   <= '0;
            rdValidQ <= 1'b0;
            rdLastQ  <= 1'b0;
            wrDoneQ  <= 1'b0;
        end else begin
            rdValidQ <= 1'b0;
            rdLastQ  <= 1'b0;
            wrDoneQ  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        baseAddr <= blockBase(req_addr);
`ifdef MAIN_MEM_CRITICAL_WORD_FIRST_EN
                        startOff <= req_write ? '0 : req_addr[OFFSET_W-1:0];
`else
                        startOff <= '0;
`endif
                        beat     <= '0;
                        latCnt   <= LAT_LOAD;
                        if (req_write) begin
                            state <= ST_WR_BURST;
                        end else if (LATENCY == 0) begin
                            state <= ST_RD_BURST;
                        end else begin
                            state <= ST_RD_WAIT;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    if (latCnt == '0) begin
                        state <= ST_RD_BURST;
                    end else begin
                        latCnt <= latCnt - CNT_W'(1);
                    end
                end
                ST_RD_BURST: begin
                    if (beat[OFFSET_W]) begin
                        // Trailing cycle: rd_last is on the bus now.
                        state <= ST_IDLE;
                    end else begin
                        rdValidQ <= 1'b1;
                        rdLastQ  <= (beat[OFFSET_W-1:0] == LAST_OFF);
                        beat     <= beat + (OFFSET_W+1)'(1);
                    end
                end
                ST_WR_BURST: begin
                    if (wr_valid) begin
                        beat <= beat + (OFFSET_W+1)'(1);
                        if (beat[OFFSET_W-1:0] == LAST_OFF) begin
                            latCnt <= LAT_LOAD;
                            state  <= (LATENCY == 0) ? ST_WR_DONE : ST_WR_WAIT;
                        end
                    end
                end
                ST_WR_WAIT: begin
                    if (latCnt == '0) begin
                        state <= ST_WR_DONE;
                    end else begin
                        latCnt <= latCnt - CNT_W'(1);
                    end
                end
                ST_WR_DONE: begin
                    // wr_done is registered, so it is seen in the first IDLE cycle.
                    wrDoneQ <= 1'b1;
                    state   <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
